// File: rtl/prbs_checker_if.sv
// Serial PRBS stream bundle: one data bit qualified by a valid strobe.
// Latency: none; this is wiring only.
// Backpressure: none; the receiver must accept every valid bit.
interface prbs_checker_if;
  logic din_valid;
  logic din;

  // Stream source side.
  modport master (
    output din_valid,
    output din
  );

  // Checker side.
  modport slave (
    input  din_valid,
    input  din
  );
endinterface

// File: rtl/prbs_checker.sv
// PRBS checker for the 8-bit XNOR LFSR (taps 7,5,4,3): self-syncs, counts bits/errors, tracks lock.
// Latency: every output is registered and reflects the valid bit of the previous cycle.
// Backpressure: none; a bit is consumed on every cycle with din_valid high, idle cycles hold state.
module prbs_checker #(
  parameter int N        = 8,
  parameter int LOCK_CNT = 16,
  parameter int WIN      = 64,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  prbs_checker_if.slave    rx,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             cnt_sat
);

  localparam int FILL_W  = (N > 1) ? $clog2(N) : 1;
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int WERR_W  = $clog2(LOSS_THR + 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       s_q, s_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [WERR_W-1:0]  werr_q, werr_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               cnt_sat_q, cnt_sat_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;

  logic               pred;
  logic               miss;
  logic               bit_inc;
  logic               err_inc;
  logic [MATCH_W-1:0] match_nxt;
  logic [WERR_W-1:0]  werr_nxt;

  // Local copy of the source feedback: the bit we expect to receive next.
  always_comb begin
    pred = ~(s_q[7] ^ s_q[5] ^ s_q[4] ^ s_q[3]);
    miss = rx.din ^ pred;
  end

  // Acquisition / tracking FSM and its fill, match and window counters.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_d       = win_q;
    werr_d      = werr_q;
    err_pulse_d = 1'b0;
    bit_inc     = 1'b0;
    err_inc     = 1'b0;
    match_nxt   = match_q;
    werr_nxt    = werr_q;

    if (rx.din_valid) begin
      case (state_q)
        ST_FILL: begin
          s_d    = {s_q[N-2:0], rx.din};
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_W'(N - 1)) begin
            state_d = ST_SYNC;
            fill_d  = '0;
            match_d = '0;
          end
        end

        ST_SYNC: begin
          // Receiver register follows the line so it re-seeds itself.
          s_d = {s_q[N-2:0], rx.din};
          if (miss) begin
            match_nxt = '0;
          end else if (s_q != {N{1'b1}}) begin
            // All-ones is the XNOR lock-up state: a match there proves nothing.
            match_nxt = match_q + MATCH_W'(1);
          end
          match_d = match_nxt;
          if (match_nxt == MATCH_W'(LOCK_CNT)) begin
            state_d = ST_LOCKED;
            win_d   = '0;
            werr_d  = '0;
          end
        end

        ST_LOCKED: begin
          // Free-run on our own prediction so a line error is counted once only.
          s_d     = {s_q[N-2:0], pred};
          bit_inc = 1'b1;
          if (miss) begin
            err_inc     = 1'b1;
            err_pulse_d = 1'b1;
            werr_nxt    = werr_q + WERR_W'(1);
          end
          werr_d = werr_nxt;
          if (werr_nxt == WERR_W'(LOSS_THR)) begin
            // Too dense: re-acquire from scratch; this bit was already counted.
            state_d = ST_FILL;
            fill_d  = '0;
          end else if (win_q == WIN_W'(WIN - 1)) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d = win_q + WIN_W'(1);
          end
        end

        default: begin
          state_d = ST_FILL;
          fill_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // Saturating bit/error counters; clear wins over a same-cycle increment.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    if (bit_inc && (bit_cnt_q != {CNT_W{1'b1}})) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
    if (err_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
    cnt_sat_d = cnt_sat_q | (&bit_cnt_d) | (&err_cnt_d);
    if (clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
      cnt_sat_d = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      s_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      cnt_sat_q   <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      cnt_sat_q   <= cnt_sat_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign bit_cnt   = bit_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign cnt_sat   = cnt_sat_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed stream scenarios, scoreboard of per-cycle expected outputs.
// Latency: expectations are pushed as a bit is driven and popped one clock later.
// Backpressure: none; the bench drives one bit (or idle) per cycle.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [31:0] bit_cnt;
  logic [31:0] err_cnt;
  logic        cnt_sat;

  prbs_checker_if rx_if ();

  prbs_checker #(
    .N(8), .LOCK_CNT(16), .WIN(64), .LOSS_THR(8), .CNT_W(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx_if),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .bit_cnt   (bit_cnt),
    .err_cnt   (err_cnt),
    .cnt_sat   (cnt_sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lk;
    logic        pl;
    logic [31:0] bc;
    logic [31:0] ec;
    logic        st;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Stream source (team LFSR) and behavioural reference.
  logic [7:0] src_r;
  int         m_st;      // 0 fill, 1 sync, 2 locked
  logic [7:0] m_s;
  int         m_fill, m_match, m_win, m_werr;
  longint     m_bit, m_err;
  bit         m_sat, m_pulse;
  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic gen(output logic b);
    b = ~(src_r[7] ^ src_r[5] ^ src_r[4] ^ src_r[3]);
    src_r = {src_r[6:0], b};
  endtask

  task automatic model_reset();
    m_st = 0; m_s = 8'h00; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_bit = 0; m_err = 0; m_sat = 0; m_pulse = 0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic clr);
    bit pred, miss;
    m_pulse = 0;
    if (v) begin
      pred = ~(m_s[7] ^ m_s[5] ^ m_s[4] ^ m_s[3]);
      miss = (b != pred);
      if (m_st == 0) begin
        m_s = {m_s[6:0], b};
        m_fill++;
        if (m_fill == 8) begin m_st = 1; m_match = 0; end
      end else if (m_st == 1) begin
        if (miss) m_match = 0;
        else if (m_s != 8'hFF) m_match++;
        m_s = {m_s[6:0], b};
        if (m_match == 16) begin m_st = 2; m_win = 0; m_werr = 0; end
      end else begin
        m_s = {m_s[6:0], pred};
        if (m_bit < CMAX) m_bit++;
        if (miss) begin
          m_pulse = 1;
          if (m_err < CMAX) m_err++;
          m_werr++;
        end
        if (m_werr == 8) begin
          m_st = 0; m_fill = 0;
        end else begin
          m_win++;
          if (m_win == 64) begin m_win = 0; m_werr = 0; end
        end
      end
    end
    if (m_bit == CMAX || m_err == CMAX) m_sat = 1;
    if (clr) begin m_bit = 0; m_err = 0; m_sat = 0; end
  endtask

  // Drive one cycle, push the expectation, then compare after the edge.
  task automatic step(input logic v, input logic b, input logic clr);
    obs_t e;
    rx_if.din_valid = v;
    rx_if.din       = b;
    clear           = clr;
    model_step(v, b, clr);
    e.lk = (m_st == 2); e.pl = m_pulse; e.bc = m_bit[31:0]; e.ec = m_err[31:0]; e.st = m_sat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sb_locked",    32'(locked),    32'(e.lk));
    check("sb_err_pulse", 32'(err_pulse), 32'(e.pl));
    check("sb_bit_cnt",   bit_cnt,        e.bc);
    check("sb_err_cnt",   err_cnt,        e.ec);
    check("sb_cnt_sat",   32'(cnt_sat),   32'(e.st));
    rx_if.din_valid = 1'b0;
    clear           = 1'b0;
  endtask

  task automatic send_clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen(b);
      step(1'b1, b, 1'b0);
    end
  endtask

  task automatic send_err();
    logic b;
    gen(b);
    step(1'b1, ~b, 1'b0);
  endtask

  // Asynchronous reset: outputs must be zero before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    rx_if.din_valid = 1'b0;
    rx_if.din = 1'b0;
    clear = 1'b0;
    #2;
    check("rst_locked",    32'(locked),    32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_bit_cnt",   bit_cnt,        32'd0);
    check("rst_err_cnt",   err_cnt,        32'd0);
    check("rst_cnt_sat",   32'(cnt_sat),   32'd0);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b;
    int   nv;
    rst_n = 1'b1;
    clear = 1'b0;
    rx_if.din_valid = 1'b0;
    rx_if.din = 1'b0;
    #1;

    // 1: seed 0x01, continuous valid: lock after bit 24, then 1000 clean bits.
    do_reset();
    src_r = 8'h01;
    for (int i = 1; i <= 26; i++) begin
      gen(b);
      step(1'b1, b, 1'b0);
      check("acq_locked", 32'(locked), (i >= 24) ? 32'd1 : 32'd0);
    end
    check("acq_bit_cnt", bit_cnt, 32'd2);
    send_clean(998);
    check("clean_bit_cnt", bit_cnt, 32'd1000);
    check("clean_err_cnt", err_cnt, 32'd0);
    check("clean_locked",  32'(locked), 32'd1);

    // 2: single error at bit_cnt = 100.
    do_reset();
    src_r = 8'hC3;
    send_clean(24);
    send_clean(100);
    check("e1_pre_bit_cnt", bit_cnt, 32'd100);
    send_err();
    check("e1_pulse",   32'(err_pulse), 32'd1);
    check("e1_err_cnt", err_cnt, 32'd1);
    check("e1_locked",  32'(locked), 32'd1);
    send_clean(1);
    check("e1_next_pulse", 32'(err_pulse), 32'd0);
    check("e1_next_err",   err_cnt, 32'd1);
    send_clean(5);
    check("e1_tail_err", err_cnt, 32'd1);

    // 3: eight errors inside one window -> loss of lock, then relock.
    do_reset();
    src_r = 8'h3C;
    send_clean(24);
    send_clean(10);
    for (int k = 1; k <= 8; k++) begin
      send_err();
      check("loss_pulse",   32'(err_pulse), 32'd1);
      check("loss_err_cnt", err_cnt, 32'(k));
      check("loss_locked",  32'(locked), (k < 8) ? 32'd1 : 32'd0);
    end
    for (int i = 1; i <= 24; i++) begin
      gen(b);
      step(1'b1, b, 1'b0);
      check("relock_locked", 32'(locked), (i >= 24) ? 32'd1 : 32'd0);
    end
    check("relock_bit_cnt", bit_cnt, 32'd18);
    check("relock_err_cnt", err_cnt, 32'd8);

    // 4: constant-1 stream must never lock.
    do_reset();
    for (int i = 0; i < 200; i++) step(1'b1, 1'b1, 1'b0);
    check("ones_locked",  32'(locked), 32'd0);
    check("ones_bit_cnt", bit_cnt, 32'd0);

    // 5: valid every other cycle, junk on idle cycles.
    do_reset();
    src_r = 8'h5A;
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      if ((i % 2) == 0) begin
        gen(b);
        step(1'b1, b, 1'b0);
        nv++;
      end else begin
        step(1'b0, 1'($urandom), 1'b0);
      end
      check("gap_locked", 32'(locked), (nv >= 24) ? 32'd1 : 32'd0);
    end
    check("gap_bit_cnt", bit_cnt, 32'd6);

    // 6: clear with a same-cycle error, then reset mid-lock.
    gen(b);
    step(1'b1, ~b, 1'b1);
    check("clr_err_cnt", err_cnt, 32'd0);
    check("clr_bit_cnt", bit_cnt, 32'd0);
    check("clr_locked",  32'(locked), 32'd1);
    send_clean(5);
    send_err();
    check("pre_rst_err_cnt", err_cnt, 32'd1);
    check("pre_rst_bit_cnt", bit_cnt, 32'd6);
    do_reset();
    check("post_rst_locked", 32'(locked), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
